// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard controller
package hazard_pkg;

  // EX-stage operand source select
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;

  // Memory-wait sequencer state
  typedef enum logic {
    HZ_RUN,
    HZ_WAIT
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - forwarding comparator for one EX operand
module hazard_fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_addr,
  input  logic [4:0] rd_M,
  input  logic       reg_wr_M,
  input  logic [4:0] rd_W,
  input  logic       reg_wr_W,
  output logic [1:0] fwd
);

  fwd_sel_e sel;

  // M is younger than W, so it wins when both write the same register; x0 never forwards
  always_comb begin
    sel = FWD_RF;
    if (reg_wr_M && (rd_M != REG_ZERO) && (rd_M == rs_addr)) begin
      sel = FWD_M;
    end else if (reg_wr_W && (rd_W != REG_ZERO) && (rd_W == rs_addr)) begin
      sel = FWD_W;
    end
  end

  assign fwd = sel;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush sequencing and forwarding control
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_E,
  input  logic             mem_rd_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic             mem_acc_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  input  logic             br_taken_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MEM_LAT) + 1;
  localparam logic [WW-1:0] LAST = WW'(MEM_LAT - 1);

  hz_state_e      state;
  logic [WW-1:0]  wcnt;
  logic           mem_stall;
  logic           load_use;
  logic [1:0]     fwd_a;
  logic [1:0]     fwd_b;

  hazard_fwd_unit u_fwd_a (
    .rs_addr  (rs1_addr_E),
    .rd_M     (rd_M),
    .reg_wr_M (reg_wr_M),
    .rd_W     (rd_W),
    .reg_wr_W (reg_wr_W),
    .fwd      (fwd_a)
  );

  hazard_fwd_unit u_fwd_b (
    .rs_addr  (rs2_addr_E),
    .rd_M     (rd_M),
    .reg_wr_M (reg_wr_M),
    .rd_W     (rd_W),
    .reg_wr_W (reg_wr_W),
    .fwd      (fwd_b)
  );

  // Memory stall on the triggering RUN cycle and on every WAIT cycle except the release one
  always_comb begin
    mem_stall = 1'b0;
    if (MEM_LAT > 1) begin
      if (state == HZ_RUN) begin
        mem_stall = mem_acc_M;
      end else begin
        mem_stall = (wcnt != LAST);
      end
    end
    load_use = mem_rd_E && (rd_E != REG_ZERO) &&
               ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));
  end

  // Priority mux: memory stall, then redirect, then load-use; everything low during reset
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (reset) begin
      if (mem_stall) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (br_taken_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  assign fwd_a_E = reset ? fwd_a : 2'b00;
  assign fwd_b_E = reset ? fwd_b : 2'b00;

  // Wait sequencer and wrapping event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= HZ_RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state == HZ_RUN) begin
        if ((MEM_LAT > 1) && mem_acc_M) begin
          state <= HZ_WAIT;
          wcnt  <= WW'(1);
        end
      end else begin
        if (wcnt == LAST) begin
          state <= HZ_RUN;
          wcnt  <= '0;
        end else begin
          wcnt <= wcnt + WW'(1);
        end
      end
      stall_cnt <= stall_cnt + CNT_W'(stall_F);
      flush_cnt <= flush_cnt + CNT_W'(flush_D);
    end
  end

endmodule
